// File: rtl/rssb_mem_arbiter_pkg.sv
// Shared types and defaults for the RSSB memory arbiter.
package rssb_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    S_OPEN    = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_t;
endpackage

// File: rtl/rssb_mem_arbiter_if.sv
// Core, host and memory-macro signals around the arbiter.
interface rssb_mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_lock;
  logic              locked;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_valid, host_we, host_addr, host_wdata, host_lock,
    output host_ready, host_rvalid, host_rdata, locked,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory macro
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_valid, host_we, host_addr, host_wdata, host_lock,
    input  host_ready, host_rvalid, host_rdata, locked,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/rssb_mem_arbiter_pick.sv
// Combinational winner select: core-first with a bounded run, host-only once lock begins.
module rssb_arb_pick
  import rssb_pkg::*;
#(
  parameter int MAX_CORE_RUN = 4
) (
  input  logic             core_req_i,
  input  logic             host_valid_i,
  input  logic [RUN_W-1:0] run_i,
  input  arb_state_t       state_i,
  output logic             core_win_o,
  output logic             host_win_o
);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CORE_RUN);

  always_comb begin
    core_win_o = 1'b0;
    host_win_o = 1'b0;
    if (state_i == S_OPEN) begin
      if (core_req_i && host_valid_i) begin
        core_win_o = (run_i < RUN_MAX);
        host_win_o = !(run_i < RUN_MAX);
      end else begin
        core_win_o = core_req_i;
        host_win_o = host_valid_i;
      end
    end else begin
      host_win_o = host_valid_i;
    end
  end
endmodule

// File: rtl/rssb_mem_arbiter.sv
// Single-port memory arbiter between the RSSB core and a host/loader port,
// with a starvation bound for the host and a host-exclusive lock mode.
module rssb_mem_arbiter
  import rssb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int MAX_CORE_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  rssb_mem_arbiter_if.slave bus
);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CORE_RUN);

  arb_state_t       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  rd_tag_t          tag_q, tag_d;
  logic             locked_q, locked_d;

  logic core_win, host_win, core_go, host_go;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  rssb_arb_pick #(.MAX_CORE_RUN(MAX_CORE_RUN)) u_pick (
    .core_req_i   (bus.core_req),
    .host_valid_i (bus.host_valid),
    .run_i        (run_q),
    .state_i      (state_q),
    .core_win_o   (core_win),
    .host_win_o   (host_win)
  );

  // No grant may leak while reset is held, even with requests present
  assign core_go = core_win & ~rst;
  assign host_go = host_win & ~rst;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (core_go) begin
      mem_we_d    = bus.core_we;
      mem_addr_d  = bus.core_addr;
      mem_wdata_d = bus.core_wdata;
    end else if (host_go) begin
      mem_we_d    = bus.host_we;
      mem_addr_d  = bus.host_addr;
      mem_wdata_d = bus.host_wdata;
    end
  end

  assign bus.core_gnt    = core_go;
  assign bus.host_ready  = host_go;
  assign bus.mem_en      = core_go | host_go;
  assign bus.mem_we      = mem_we_d;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_wdata   = mem_wdata_d;
  assign bus.core_rvalid = (tag_q == TAG_CORE);
  assign bus.host_rvalid = (tag_q == TAG_HOST);
  assign bus.core_rdata  = (tag_q == TAG_CORE) ? bus.mem_rdata : '0;
  assign bus.host_rdata  = (tag_q == TAG_HOST) ? bus.mem_rdata : '0;
  assign bus.locked      = locked_q;

  always_comb begin
    state_d = state_q;
    run_d   = '0;
    case (state_q)
      S_OPEN: begin
        if (bus.host_lock) state_d = S_LOCKING;
        if (core_win && bus.host_valid)
          run_d = (run_q < RUN_MAX) ? run_q + 1'b1 : run_q;
      end
      // The core cannot be granted here, and a core read tagged on entry
      // retires this very cycle, so one LOCKING cycle always suffices.
      S_LOCKING: state_d = bus.host_lock ? S_LOCKED : S_OPEN;
      S_LOCKED:  if (!bus.host_lock) state_d = S_OPEN;
      default:   state_d = S_OPEN;
    endcase
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (core_go && !bus.core_we)      tag_d = TAG_CORE;
    else if (host_go && !bus.host_we) tag_d = TAG_HOST;
  end

  assign locked_d = (state_d == S_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OPEN;
      run_q    <= '0;
      tag_q    <= TAG_NONE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      tag_q    <= tag_d;
      locked_q <= locked_d;
    end
  end
endmodule

// File: tb/tb_rssb_mem_arbiter.sv
// Bench for rssb_mem_arbiter: fixed vectors, lock/unlock/reset sequences, then random traffic vs. a model.
module tb_rssb_mem_arbiter;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rssb_mem_arbiter_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  rssb_mem_arbiter #(.DATA_W(16), .ADDR_W(8), .MAX_CORE_RUN(MAXR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'h00A5 : {a ^ 8'h3C, a};
  endfunction

  // Synchronous memory macro
  logic [15:0] mem [256];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic creq, cwe; logic [7:0] caddr; logic [15:0] cwd;
    logic hv, hwe;   logic [7:0] haddr; logic [15:0] hwd;
    logic lock;
  } stim_t;

  typedef struct {
    stim_t s;
    logic cgnt, hrdy, men, mwe; logic [7:0] maddr; logic [15:0] mwd;
    logic crv; logic [15:0] crd; logic hrv; logic [15:0] hrd; logic lkd;
  } vec_t;

  int n_chk = 0, n_err = 0, cyc = 0;

  // Reference model: lock age in cycles, core-run streak, one pending read, shadow memory
  int lock_age, streak, pend;
  logic [15:0] pend_data;
  logic [15:0] ref_mem [256];

  function automatic stim_t st(logic creq, logic cwe, logic [7:0] caddr, logic [15:0] cwd,
                               logic hv, logic hwe, logic [7:0] haddr, logic [15:0] hwd, logic lock);
    stim_t s;
    s.creq = creq; s.cwe = cwe; s.caddr = caddr; s.cwd = cwd;
    s.hv = hv; s.hwe = hwe; s.haddr = haddr; s.hwd = hwd; s.lock = lock;
    return s;
  endfunction

  function automatic vec_t ex(stim_t s, logic cg, logic hr, logic me, logic mw, logic [7:0] ma,
                              logic [15:0] md, logic crv, logic [15:0] crd, logic hrv,
                              logic [15:0] hrd, logic lk);
    vec_t v;
    v.s = s; v.cgnt = cg; v.hrdy = hr; v.men = me; v.mwe = mw; v.maddr = ma; v.mwd = md;
    v.crv = crv; v.crd = crd; v.hrv = hrv; v.hrd = hrd; v.lkd = lk;
    return v;
  endfunction

  function automatic vec_t model_expect(stim_t s);
    logic cw, hw;
    if (lock_age >= 1) begin
      cw = 1'b0; hw = s.hv;
    end else if (s.creq && s.hv) begin
      cw = (streak < MAXR); hw = !cw;
    end else begin
      cw = s.creq; hw = s.hv;
    end
    return ex(s, cw, hw, cw | hw,
              cw ? s.cwe : (hw ? s.hwe : 1'b0),
              cw ? s.caddr : (hw ? s.haddr : 8'h00),
              cw ? s.cwd : (hw ? s.hwd : 16'h0000),
              pend == 1, (pend == 1) ? pend_data : 16'h0000,
              pend == 2, (pend == 2) ? pend_data : 16'h0000,
              lock_age >= 2);
  endfunction

  task automatic model_update(input stim_t s);
    vec_t e;
    e = model_expect(s);
    pend = 0;
    if (e.cgnt && !s.cwe)      begin pend = 1; pend_data = ref_mem[s.caddr]; end
    else if (e.hrdy && !s.hwe) begin pend = 2; pend_data = ref_mem[s.haddr]; end
    if (e.cgnt && s.cwe) ref_mem[s.caddr] = s.cwd;
    if (e.hrdy && s.hwe) ref_mem[s.haddr] = s.hwd;
    if (lock_age == 0 && e.cgnt && s.hv) streak++;
    else streak = 0;
    lock_age = s.lock ? ((lock_age >= 2) ? 2 : lock_age + 1) : 0;
  endtask

  task automatic model_reset();
    lock_age = 0; streak = 0; pend = 0; pend_data = '0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.core_req = s.creq; bus.core_we = s.cwe; bus.core_addr = s.caddr; bus.core_wdata = s.cwd;
    bus.host_valid = s.hv; bus.host_we = s.hwe; bus.host_addr = s.haddr; bus.host_wdata = s.hwd;
    bus.host_lock = s.lock;
  endtask

  task automatic compare(input vec_t e);
    chk("core_gnt",    16'(bus.core_gnt),    16'(e.cgnt));
    chk("host_ready",  16'(bus.host_ready),  16'(e.hrdy));
    chk("mem_en",      16'(bus.mem_en),      16'(e.men));
    chk("mem_we",      16'(bus.mem_we),      16'(e.mwe));
    chk("mem_addr",    16'(bus.mem_addr),    16'(e.maddr));
    chk("mem_wdata",   bus.mem_wdata,        e.mwd);
    chk("core_rvalid", 16'(bus.core_rvalid), 16'(e.crv));
    chk("core_rdata",  bus.core_rdata,       e.crd);
    chk("host_rvalid", 16'(bus.host_rvalid), 16'(e.hrv));
    chk("host_rdata",  bus.host_rdata,       e.hrd);
    chk("locked",      16'(bus.locked),      16'(e.lkd));
  endtask

  // Entered and left at posedge+1
  task automatic apply_cycle(input vec_t e);
    drive(e.s);
    @(negedge clk);
    compare(e);
    @(posedge clk);
    model_update(e.s);
    cyc++;
    #1;
  endtask

  task automatic run_model(input stim_t s);
    apply_cycle(model_expect(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [16];

  initial begin
    stim_t idle, cr, hw, hr, br, s, cstim;
    bit cpend;

    idle = st(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
    cr   = st(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 0);
    hw   = st(0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h1234, 0);
    hr   = st(0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000, 0);
    br   = st(1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 0);

    tbl[0] = ex(cr,   1, 0, 1, 0, 8'h10, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[1] = ex(idle, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 16'h00A5, 0, 16'h0000, 0);
    tbl[2] = ex(hw,   0, 1, 1, 1, 8'h20, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[3] = ex(hr,   0, 1, 1, 0, 8'h20, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[4] = ex(idle, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 16'h1234, 0);
    // Contention: C,C,C,C,H,C,C,C,C,H
    for (int k = 0; k < 10; k++) begin
      bit h, ph;
      h  = (k == 4) || (k == 9);
      ph = (k == 5);
      tbl[5+k] = ex(br, !h, h, 1, 0, h ? 8'h20 : 8'h10, 16'h0000,
                    (k > 0) && !ph, ((k > 0) && !ph) ? 16'h00A5 : 16'h0000,
                    ph, ph ? 16'h1234 : 16'h0000, 0);
    end
    tbl[15] = ex(idle, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 16'h1234, 0);

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    model_reset();

    // Reset: grants suppressed even with requests and lock present
    s = br; s.lock = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(ex(s, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0));
    @(posedge clk); #1;
    drive(idle);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply_cycle(tbl[i]);

    // Lock entry while a core read is in flight, then host-exclusive traffic
    s = cr; s.lock = 1'b1;
    run_model(s);
    for (int i = 0; i < 10; i++) begin
      s = cr; s.lock = 1'b1; s.hv = 1'b1;
      s.hwe = i[0] ? 1'b0 : 1'b1;
      s.haddr = 8'h30 + 8'(i / 2);
      s.hwd = 16'h1111 * 16'(i + 1);
      run_model(s);
      if (i >= 1) chk("lock_core_blocked", 16'(bus.locked), 16'h1);
    end

    // Release: next cycle unlocked, contention restarts from run 0
    s = br; run_model(s);
    for (int i = 0; i < 6; i++) run_model(br);

    // Relock, issue a host read, then reset with its data still pending
    s = hr; s.lock = 1'b1;
    for (int i = 0; i < 3; i++) run_model(s);
    rst = 1'b1;
    #1;
    chk("rst_host_rvalid", 16'(bus.host_rvalid), 16'h0);
    chk("rst_locked",      16'(bus.locked),      16'h0);
    chk("rst_host_ready",  16'(bus.host_ready),  16'h0);
    chk("rst_mem_en",      16'(bus.mem_en),      16'h0);
    drive(idle);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_model(cr);
    run_model(idle);

    // Random traffic; the core holds its request until granted
    cpend = 1'b0;
    cstim = idle;
    s = idle;
    for (int i = 0; i < 600; i++) begin
      if (!cpend) begin
        cstim.creq  = ($urandom_range(3) != 0);
        cstim.cwe   = $urandom_range(1);
        cstim.caddr = 8'($urandom_range(15));
        cstim.cwd   = 16'($urandom);
      end
      s.creq = cstim.creq; s.cwe = cstim.cwe; s.caddr = cstim.caddr; s.cwd = cstim.cwd;
      s.hv    = ($urandom_range(2) != 0);
      s.hwe   = $urandom_range(1);
      s.haddr = 8'($urandom_range(15));
      s.hwd   = 16'($urandom);
      if ($urandom_range(11) == 0) s.lock = !s.lock;
      cpend = s.creq && !model_expect(s).cgnt;
      run_model(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
